// File: rtl/instr_prefetch_queue.sv
// In-order instruction prefetch queue between the IROM fetch path and the control FSM.
// Optional same-cycle bypass of an empty queue when IPQ_BYPASS_EN is defined.
module instr_prefetch_queue #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         Clock,
  input  logic                         Reset_n,
  input  logic                         Flush,
  input  logic                         In_valid,
  output logic                         In_ready,
  input  logic [WIDTH-1:0]             Data_in,
  output logic                         Out_valid,
  input  logic                         Out_ready,
  output logic [WIDTH-1:0]             Data_out,
  output logic [$clog2(DEPTH+1)-1:0]   Count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] head;
  logic             q_valid, q_ready;
  logic             push, pop;
  logic             bypass, bypass_take;

  assign head    = mem_q[rd_ptr_q];
  assign q_valid = (count_q != '0);
  assign q_ready = (count_q < DepthCnt);

`ifdef IPQ_BYPASS_EN
  assign bypass = !q_valid && In_valid && !Flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word consumed in the same cycle never enters storage.
  assign bypass_take = bypass && Out_ready;
  assign push        = In_valid && q_ready && !Flush && !bypass_take;
  assign pop         = q_valid && Out_ready && !Flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
    // Keep the head visible once the queue drains (IR hold behaviour).
    if (q_valid && (pop || Flush)) begin
      hold_d = head;
    end else if (bypass_take) begin
      hold_d = Data_in;
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  // Storage needs no reset; its contents are only read while count_q covers them.
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= Data_in;
  end

  assign In_ready  = q_ready;
  assign Out_valid = q_valid || bypass;
  assign Count     = count_q;

  always_comb begin
    if (bypass)       Data_out = Data_in;
    else if (q_valid) Data_out = head;
    else              Data_out = hold_q;
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue (WIDTH=16, DEPTH=4); follows IPQ_BYPASS_EN if defined.
module tb_instr_prefetch_queue;

`ifdef IPQ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Flush;
  logic        In_valid;
  logic        In_ready;
  logic [15:0] Data_in;
  logic        Out_valid;
  logic        Out_ready;
  logic [15:0] Data_out;
  logic [2:0]  Count;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  int mcount = 0;

  instr_prefetch_queue #(.WIDTH(16), .DEPTH(4)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Flush    (Flush),
    .In_valid (In_valid),
    .In_ready (In_ready),
    .Data_in  (Data_in),
    .Out_valid(Out_valid),
    .Out_ready(Out_ready),
    .Data_out (Data_out),
    .Count    (Count)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Set inputs for the coming edge and advance the reference model.
  task automatic drive(input bit iv, input logic [15:0] d, input bit ordy, input bit fl);
    bit byp;
    bit push_ok;
    bit pop_ok;
    In_valid  = iv;
    Data_in   = d;
    Out_ready = ordy;
    Flush     = fl;
    byp = Byp && (mcount == 0) && iv && ordy && !fl;
    if (fl) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      push_ok = iv && (mcount < 4) && !byp;
      pop_ok  = ordy && (mcount > 0);
      if (iv && (mcount < 4)) exp_q.push_back(d);
      mcount = mcount + int'(push_ok) - int'(pop_ok);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Monitor: every handshake that will fire at the next edge is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge Clock);
      if (Reset_n && Out_valid && Out_ready && !Flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %h expected none at %0t", Data_out, $time);
        end else begin
          check("head_order", {16'h0, Data_out}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0;
    drive(0, 16'h0, 0, 0);
    #2;
    check("rst_count", {29'h0, Count}, 32'd0);
    check("rst_out_valid", {31'h0, Out_valid}, 32'd0);
    check("rst_in_ready", {31'h0, In_ready}, 32'd1);
    check("rst_data_out", {16'h0, Data_out}, 32'h0);
    #1 Reset_n = 1'b1;
    step();

    // Latency / bypass on an empty queue.
    drive(1, 16'hC0DE, 1, 0);
    #1;
    check("byp_out_valid", {31'h0, Out_valid}, {31'h0, Byp});
    check("byp_data_out", {16'h0, Data_out}, Byp ? 32'h0000_C0DE : 32'h0);
    step();
    drive(0, 16'h0, 0, 0);
    #1;
    check("byp_count", {29'h0, Count}, {31'h0, !Byp});
    check("byp_next_valid", {31'h0, Out_valid}, {31'h0, !Byp});
    check("byp_next_data", {16'h0, Data_out}, 32'h0000_C0DE);
    step();
    drive(0, 16'h0, 1, 0);
    step();

    // Fill, overflow attempt, then drain in order.
    drive(1, 16'h1111, 0, 0); step();
    drive(1, 16'h2222, 0, 0); step();
    drive(1, 16'h3333, 0, 0); step();
    drive(1, 16'h4444, 0, 0); step();
    check("full_count", {29'h0, Count}, 32'd4);
    check("full_in_ready", {31'h0, In_ready}, 32'd0);
    drive(1, 16'h5555, 0, 0); step();
    check("full_reject", {29'h0, Count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 16'h0, 1, 0);
      step();
    end
    drive(0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {31'h0, Out_valid}, 32'd0);
      check("hold_data", {16'h0, Data_out}, 32'h0000_4444);
      step();
    end

    // Continuous streaming through wrapping pointers.
    for (int i = 1; i <= 10; i++) begin
      drive(1, 16'(i), 1, 0);
      step();
      check("stream_count", {29'h0, Count}, {31'h0, !Byp});
    end
    drive(0, 16'h0, 1, 0);
    step();
    check("stream_drained", {29'h0, Count}, 32'd0);

    // Flush with concurrent push and pop.
    drive(1, 16'hAAAA, 0, 0); step();
    drive(1, 16'h1234, 0, 0); step();
    drive(1, 16'h5678, 0, 0); step();
    check("pre_flush_count", {29'h0, Count}, 32'd3);
    check("pre_flush_head", {16'h0, Data_out}, 32'h0000_AAAA);
    drive(1, 16'hBBBB, 1, 1);
    step();
    check("flush_count", {29'h0, Count}, 32'd0);
    check("flush_valid", {31'h0, Out_valid}, 32'd0);
    check("flush_data", {16'h0, Data_out}, 32'h0000_AAAA);
    drive(0, 16'h0, 0, 0);
    step();
    check("flush_hold", {16'h0, Data_out}, 32'h0000_AAAA);

    // Asynchronous reset in mid-cycle with two words queued.
    drive(1, 16'h0101, 0, 0); step();
    drive(1, 16'h0202, 0, 0); step();
    drive(0, 16'h0, 0, 0);
    check("pre_rst_count", {29'h0, Count}, 32'd2);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_count", {29'h0, Count}, 32'd0);
    check("arst_valid", {31'h0, Out_valid}, 32'd0);
    check("arst_data", {16'h0, Data_out}, 32'h0);
    check("arst_in_ready", {31'h0, In_ready}, 32'd1);
    exp_q.delete();
    mcount = 0;
    #3 Reset_n = 1'b1;
    step();
    drive(1, 16'h0303, 0, 0); step();
    drive(0, 16'h0, 1, 0); step();
    drive(0, 16'h0, 0, 0); step();
    check("post_rst_count", {29'h0, Count}, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Parametrised instruction register that generalises the single-entry, load-enabled IR into a DEPTH-entry in-order prefetch queue. It sits between the instruction ROM fetch path and the control-unit FSM. Fetched words are accepted with a valid/ready handshake and held until the FSM consumes them. A synchronous flush discards prefetched words on a branch or jump.

## Interface
Parameters:
- WIDTH, default 16: instruction word width in bits.
- DEPTH, default 4: number of queue entries. Must be a power of two and at least 2.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Flush  input  1  synchronous discard of all queued words.
- In_valid  input  1  the fetch side presents a word on Data_in.
- In_ready  output  1  the queue can accept a word this cycle.
- Data_in  input  WIDTH  instruction word from the IROM.
- Out_valid  output  1  Data_out holds a valid head instruction.
- Out_ready  input  1  the FSM consumes the head this cycle.
- Data_out  output  WIDTH  head instruction to the FSM.
- Count  output  $clog2(DEPTH+1)  number of queued words.

## Operation
- Push: a word is accepted on a rising edge when In_valid and In_ready are both high. Words are stored in arrival order.
- Pop: the head is removed on a rising edge when Out_valid and Out_ready are both high.
- In_ready = (Count < DEPTH). There is no pass-through when full, so a simultaneous pop does not free a slot in the same cycle.
- Out_valid = (Count > 0), except in the bypass case described under Configuration.
- Simultaneous push and pop with 0 < Count < DEPTH: Count is unchanged, the new word goes to the tail, and the next word becomes the head.
- Data_out shows the head entry while Out_valid is high.
- When the queue is empty, Data_out holds the last popped word, preserving the IR hold semantics. The FSM may still read the current instruction after popping it.
- Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Full and empty are decided from Count only.
- Flush, when high at a rising edge:
  - Count, pointers and Out_valid clear.
  - Any push or pop in the same cycle is ignored.
  - Data_out keeps its current value.
- Reset_n low (asynchronous, at any time, including mid-transfer):
  - Count = 0, Out_valid = 0, In_ready = 1, Data_out = 0, pointers = 0.
  - Storage contents are don't-care.
- Handshake rule: Out_valid must never depend combinationally on Out_ready. In_ready must never depend on In_valid.

## Timing
- Push-to-output latency is 1 cycle. A word accepted at edge N into an empty queue appears on Data_out with Out_valid = 1 after edge N.
- Pop takes effect at the edge. The following head appears after that same edge.
- Count updates at the edge of the push, pop or flush.
- Sustained throughput is one word per cycle while 0 < Count < DEPTH with both sides active.
- Outputs other than the bypass path are registered or decoded only from registered state.
- Reset assertion acts immediately. Deassertion takes effect at the next rising edge.

## Configuration
- IPQ_BYPASS_EN defined:
  - When Count == 0 and In_valid is high, Out_valid is driven high and Data_out = Data_in combinationally.
  - If Out_ready is also high, the word is consumed without being stored. Count stays 0 and the Data_out hold register captures Data_in.
  - If Out_ready is low, the word is stored normally.
  - Flush suppresses the bypass.
- IPQ_BYPASS_EN undefined: the 1-cycle latency path only. Out_valid is purely registered.

## Test plan
All scenarios use WIDTH = 16 and DEPTH = 4.
- Reset: assert Reset_n = 0 mid-cycle with Count = 2 -> Count, Out_valid and Data_out go to 0 immediately; In_ready = 1.
- Fill: push 0x1111, 0x2222, 0x3333, 0x4444 with Out_ready = 0, then In_valid = 1 with 0x5555 -> Count = 4, In_ready = 0, 0x5555 is not accepted. Then pop four times -> Data_out shows 0x1111, 0x2222, 0x3333, 0x4444 in order.
- Hold after empty: after the last pop of 0x4444 -> Out_valid = 0, Data_out stays 0x4444 for at least 3 cycles.
- Wrap and stream: push and pop 10 words 0x0001..0x000A with both handshakes high continuously -> Count stays at 1 after the first word, output order is preserved, and pointers wrap twice without error.
- Flush: with Count = 3 and head 0xAAAA, assert Flush together with a push of 0xBBBB and Out_ready = 1 -> Count = 0, Out_valid = 0, 0xBBBB is dropped, Data_out = 0xAAAA.
- Bypass (IPQ_BYPASS_EN defined): empty queue, In_valid = 1, Data_in = 0xC0DE, Out_ready = 1 -> Out_valid = 1 and Data_out = 0xC0DE in the same cycle, Count stays 0. Without the macro -> Out_valid goes to 1 one cycle later and Count goes to 1.
